// File: rtl/thee_freq_meas_scheduler.sv
// Frequency measurement sequencer: time-shares one synchronised rising-edge counter across
// NUM_CH slow inputs, sweeping enabled channels in ascending order over a programmable gate.
module thee_freq_meas_scheduler #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GATE_W        = 20,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [GATE_W-1:0]         gate_cycles,
    input  logic [NUM_CH-1:0]         sig_in,
    output logic                      busy,
    output logic                      res_valid,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]          res_count,
    output logic                      res_overflow,
    output logic                      sweep_done
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam logic [GATE_W-1:0] SettleLoad = GATE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StGate,
        StReport
    } state_e;

    state_e              state_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [GATE_W-1:0]   gate_q;
    logic [CH_W-1:0]     ch_q;
    logic [GATE_W-1:0]   timer_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;

    logic [NUM_CH-1:0]   sig_meta_q;
    logic [NUM_CH-1:0]   sig_sync_q;
    logic [NUM_CH-1:0]   sig_prev_q;

    logic                edge_det;
    logic [CNT_W-1:0]    cnt_upd;
    logic                ovf_upd;
    logic [GATE_W-1:0]   gate_eff;
    logic [CH_W-1:0]     first_ch;
    logic                first_found;
    logic [CH_W-1:0]     next_ch;
    logic                next_found;

    // Free-running two-flop synchroniser plus one delay stage for edge detection. Left out of
    // reset so a high input does not look like a fresh rising edge after reset.
    always_ff @(posedge clk) begin
        sig_meta_q <= sig_in;
        sig_sync_q <= sig_meta_q;
        sig_prev_q <= sig_sync_q;
    end

    assign edge_det = sig_sync_q[ch_q] & ~sig_prev_q[ch_q];
    assign gate_eff = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

    // Saturating counter update; overflow is sticky for the rest of the window.
    always_comb begin
        cnt_upd = cnt_q;
        ovf_upd = ovf_q;
        if (edge_det) begin
            if (&cnt_q) begin
                ovf_upd = 1'b1;
            end else begin
                cnt_upd = cnt_q + 1'b1;
            end
        end
    end

    // Downward scan so the last hit is the lowest qualifying index.
    always_comb begin
        first_ch    = '0;
        first_found = 1'b0;
        next_ch     = '0;
        next_found  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                first_ch    = CH_W'(i);
                first_found = 1'b1;
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch    = CH_W'(i);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            gate_q       <= '0;
            ch_q         <= '0;
            timer_q      <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            res_ch       <= '0;
            res_count    <= '0;
            res_overflow <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            res_valid  <= 1'b0;
            sweep_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (first_found) begin
                            mask_q  <= ch_enable;
                            gate_q  <= gate_eff;
                            ch_q    <= first_ch;
                            timer_q <= SettleLoad;
                            cnt_q   <= '0;
                            ovf_q   <= 1'b0;
                            busy    <= 1'b1;
                            state_q <= StSettle;
                        end else begin
                            sweep_done <= 1'b1;
                        end
                    end
                end
                StSettle: begin
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                    if (timer_q == '0) begin
                        timer_q <= gate_q - 1'b1;
                        state_q <= StGate;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                StGate: begin
                    cnt_q <= cnt_upd;
                    ovf_q <= ovf_upd;
                    if (timer_q == '0) begin
                        // Result registered here so it is visible during the REPORT cycle,
                        // including an edge seen in the final gate cycle.
                        res_valid    <= 1'b1;
                        res_ch       <= ch_q;
                        res_count    <= cnt_upd;
                        res_overflow <= ovf_upd;
                        sweep_done   <= ~next_found;
                        state_q      <= StReport;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                StReport: begin
                    if (next_found) begin
                        ch_q    <= next_ch;
                        timer_q <= SettleLoad;
                        state_q <= StSettle;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
